sqrt_scheduler: RTL and testbench

Round-robin scheduler that shares one structural square-root core (control path plus datapath) among several requesters. It accepts an operand from one requester at a time, launches the core, and watches for completion with a watchdog. It then returns the root, tagged with the requester index, over a valid/ready response channel. It sits between the client blocks and the single square-root instance.

---
 rtl/sqrt_sched_pkg.sv | 15 +
 rtl/sqrt_rr_arbiter.sv | 40 ++++
 rtl/sqrt_scheduler.sv | 124 ++++++++++++
 tb/tb_sqrt_scheduler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_sched_pkg.sv
// Shared types for the square-root scheduler: FSM state encoding and index-width helper.
package sqrt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sqrt_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr_i, wrapping.
module sqrt_rr_arbiter
  import sqrt_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDXW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDXW-1:0] grant_idx_o,
  output logic            any_valid_o
);

  logic [IDXW-1:0] w_cand [NREQ];

  // w_cand[k] is the requester index visited k steps after the pointer
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
      logic [IDXW:0] w_sum;
      assign w_sum = {1'b0, ptr_i} + (IDXW+1)'(gi);
      assign w_cand[gi] = (w_sum >= (IDXW+1)'(NREQ)) ?
                          IDXW'(w_sum - (IDXW+1)'(NREQ)) : w_sum[IDXW-1:0];
    end
  endgenerate

  always_comb begin
    grant_idx_o = '0;
    any_valid_o = 1'b0;
    grant_o     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_i[w_cand[k]]) begin
        grant_idx_o = w_cand[k];
        any_valid_o = 1'b1;
      end
    end
    if (any_valid_o) grant_o[grant_idx_o] = 1'b1;
  end

endmodule

// File: rtl/sqrt_scheduler.sv
// Round-robin scheduler sharing one external square-root core among NREQ requesters,
// with a watchdog on core completion and a valid/ready tagged response channel.
module sqrt_scheduler
  import sqrt_sched_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int WIDTH   = 8,
  parameter  int TIMEOUT = 255,
  localparam int IDXW    = idx_w(NREQ),
  localparam int RW      = WIDTH / 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*WIDTH-1:0] req_data_i,
  output logic [NREQ-1:0]       req_ready_o,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [IDXW-1:0]       rsp_id_o,
  output logic [RW-1:0]         rsp_root_o,
  output logic                  rsp_err_o,
  output logic                  sqrt_start_o,
  output logic [WIDTH-1:0]      sqrt_operand_o,
  input  logic                  sqrt_done_i,
  input  logic [RW-1:0]         sqrt_root_i,
  output logic                  busy_o
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT);

  state_t           r_state;
  logic [IDXW-1:0]  r_rr_ptr;
  logic [WIDTH-1:0] r_op;
  logic [IDXW-1:0]  r_id;
  logic [RW-1:0]    r_root;
  logic             r_err;
  logic [WDW-1:0]   r_wd;
  logic             r_start;
  logic             r_rsp_valid;

  logic [NREQ-1:0]  w_grant;
  logic [IDXW-1:0]  w_gidx;
  logic             w_any;
  logic [WIDTH-1:0] w_sel_data;
  logic [IDXW-1:0]  w_next_ptr;

  sqrt_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i       (req_valid_i),
    .ptr_i       (r_rr_ptr),
    .grant_o     (w_grant),
    .grant_idx_o (w_gidx),
    .any_valid_o (w_any)
  );

  assign w_sel_data = req_data_i[w_gidx*WIDTH +: WIDTH];
  assign w_next_ptr = (r_id == IDXW'(NREQ - 1)) ? '0 : r_id + 1'b1;

  // Gated by rst so the accept strobe is silent while reset is held
  assign req_ready_o    = (r_state == IDLE && !rst) ? w_grant : '0;
  assign rsp_valid_o    = r_rsp_valid;
  assign rsp_id_o       = r_id;
  assign rsp_root_o     = r_root;
  assign rsp_err_o      = r_err;
  assign sqrt_start_o   = r_start;
  assign sqrt_operand_o = r_op;
  assign busy_o         = (r_state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_op        <= '0;
      r_id        <= '0;
      r_root      <= '0;
      r_err       <= 1'b0;
      r_wd        <= '0;
      r_start     <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_start <= 1'b0;
          if (w_any) begin
            r_op    <= w_sel_data;
            r_id    <= w_gidx;
            r_start <= 1'b1;
            r_state <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_start <= 1'b0;
          r_wd    <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_wd != WD_MAX) r_wd <= r_wd + 1'b1;
          // Completion takes priority over a coincident watchdog expiry
          if (sqrt_done_i) begin
            r_root      <= sqrt_root_i;
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else if (r_wd == WD_LAST) begin
            r_root      <= '0;
            r_err       <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            r_rr_ptr    <= w_next_ptr;
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_scheduler.sv
// Directed bench for sqrt_scheduler with a behavioural square-root core on the side.
module tb_sqrt_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_root;
  logic        sqrt_start, sqrt_done, busy;
  logic [7:0]  sqrt_operand;
  logic [3:0]  sqrt_root;

  logic        core_en, core_done, man_done;
  int          core_lat;
  logic [3:0]  core_root, man_root;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign sqrt_done = core_done | man_done;
  assign sqrt_root = core_done ? core_root : man_root;

  sqrt_scheduler #(.NREQ(4), .WIDTH(8), .TIMEOUT(20)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid),
    .req_data_i     (req_data),
    .req_ready_o    (req_ready),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_id_o       (rsp_id),
    .rsp_root_o     (rsp_root),
    .rsp_err_o      (rsp_err),
    .sqrt_start_o   (sqrt_start),
    .sqrt_operand_o (sqrt_operand),
    .sqrt_done_i    (sqrt_done),
    .sqrt_root_i    (sqrt_root),
    .busy_o         (busy)
  );

  function automatic logic [3:0] isqrt(input logic [7:0] x);
    int r = 0;
    while ((r + 1) * (r + 1) <= int'(x)) r++;
    return r[3:0];
  endfunction

  // Core model: done pulse core_lat cycles after the start pulse
  initial begin
    logic [7:0] op;
    core_done = 1'b0;
    core_root = '0;
    forever begin
      @(negedge clk);
      if (core_en && sqrt_start === 1'b1) begin
        op = sqrt_operand;
        repeat (core_lat) @(negedge clk);
        core_done = 1'b1;
        core_root = isqrt(op);
        @(negedge clk);
        core_done = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with valids set; returns at the negedge of cycle 1
  task automatic start_txn(input string tag, input logic [3:0] exp_ready, input logic [7:0] exp_op);
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'(exp_ready));
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_start"}, 32'({sqrt_start, sqrt_operand, req_ready}), 32'({1'b1, exp_op, 4'b0}));
  endtask

  task automatic wait_rsp(input string tag, input int exp_n, input logic [1:0] exp_id, input logic exp_err);
    int n = 1;
    while (rsp_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
      if (n == 2) chk({tag, "_start_once"}, 32'(sqrt_start), 32'(0));
    end
    chk({tag, "_latency"}, 32'(n), 32'(exp_n));
    chk({tag, "_id_err"}, 32'({rsp_id, rsp_err}), 32'({exp_id, exp_err}));
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, 32'(rsp_valid), 32'(0));
  endtask

  initial begin
    int rt;
    logic [3:0] exp_rr_ready [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] exp_rr_root  [5] = '{4'd0, 4'd1, 4'd15, 4'd9, 4'd0};
    rst = 1'b1; req_valid = 4'hF; req_data = '0; rsp_ready = 1'b0;
    core_en = 1'b0; core_lat = 1; man_done = 1'b0; man_root = '0;

    // Reset state with all requesters asserting valid
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({req_ready, rsp_valid, rsp_id, rsp_root, rsp_err, sqrt_start, sqrt_operand, busy}), 32'(0));
    req_valid = '0;
    rst = 1'b0;
    @(negedge clk);

    // Basic: requester 2, 144 -> 12, core latency 5
    core_en = 1'b1; core_lat = 5;
    req_valid = 4'b0100; req_data = {8'd0, 8'd144, 8'd0, 8'd0};
    start_txn("basic", 4'b0100, 8'd144);
    req_valid = '0;
    wait_rsp("basic", 7, 2'd2, 1'b0);
    chk("basic_root", 32'(rsp_root), 32'(12));
    finish_rsp("basic");

    // Round-robin from a fresh pointer, all four requesters valid
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'hF; req_data = {8'd81, 8'd255, 8'd1, 8'd0};
    for (int t = 0; t < 5; t++) begin
      core_lat = (t % 4) + 1;
      start_txn($sformatf("rr%0d", t), exp_rr_ready[t], req_data[(t%4)*8 +: 8]);
      wait_rsp($sformatf("rr%0d", t), core_lat + 2, 2'(t % 4), 1'b0);
      chk($sformatf("rr%0d_root", t), 32'(rsp_root), 32'(exp_rr_root[t]));
      finish_rsp($sformatf("rr%0d", t));
    end
    req_valid = '0;

    // Backpressure: pointer is 1 after the wrap; hold the response for 10 cycles
    core_lat = 3;
    req_valid = 4'b0010; req_data = {8'd0, 8'd0, 8'd200, 8'd0};
    start_txn("bp", 4'b0010, 8'd200);
    wait_rsp("bp", 5, 2'd1, 1'b0);
    req_valid = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", i), 32'({rsp_valid, rsp_id, rsp_root, rsp_err, req_ready, sqrt_start}),
          32'({1'b1, 2'd1, 4'd14, 1'b0, 4'b0, 1'b0}));
    end
    finish_rsp("bp");
    req_valid = '0;

    // Timeout on requester 3; a stray done in RESP must not change the result
    core_en = 1'b0;
    req_valid = 4'b1000; req_data = {8'd50, 8'd0, 8'd0, 8'd0};
    start_txn("to", 4'b1000, 8'd50);
    req_valid = '0;
    wait_rsp("to", 22, 2'd3, 1'b1);
    chk("to_root", 32'(rsp_root), 32'(0));
    man_done = 1'b1; man_root = 4'd7;
    @(negedge clk);
    man_done = 1'b0;
    chk("to_stray_done", 32'({rsp_valid, rsp_root, rsp_err}), 32'({1'b1, 4'd0, 1'b1}));
    finish_rsp("to");

    // Done coincident with the last WAIT cycle: done wins
    req_valid = 4'b0001; req_data = {8'd0, 8'd0, 8'd0, 8'd99};
    start_txn("co", 4'b0001, 8'd99);
    req_valid = '0;
    repeat (20) @(negedge clk);
    chk("co_not_yet", 32'(rsp_valid), 32'(0));
    man_done = 1'b1; man_root = 4'd9;
    @(negedge clk);
    man_done = 1'b0;
    chk("co_result", 32'({rsp_valid, rsp_id, rsp_root, rsp_err}), 32'({1'b1, 2'd0, 4'd9, 1'b0}));
    finish_rsp("co");

    // Reset during WAIT, then service restarts at requester 0
    req_valid = 4'b0010; req_data = {8'd0, 8'd0, 8'd16, 8'd0};
    start_txn("mr", 4'b0010, 8'd16);
    repeat (3) @(negedge clk);
    chk("mr_busy", 32'(busy), 32'(1));
    rst = 1'b1;
    #1;
    chk("mr_async_clear", 32'({req_ready, rsp_valid, rsp_id, rsp_root, rsp_err, sqrt_start, sqrt_operand, busy}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    core_en = 1'b1; core_lat = 2;
    req_valid = 4'hF; req_data = {8'd0, 8'd0, 8'd0, 8'd36};
    start_txn("mr_restart", 4'b0001, 8'd36);
    req_valid = '0;
    wait_rsp("mr_restart", 4, 2'd0, 1'b0);
    chk("mr_restart_root", 32'(rsp_root), 32'(6));
    finish_rsp("mr_restart");

    // All operands through the core model; root checked by the bracketing property
    for (int x = 0; x < 256; x++) begin
      core_lat = 1 + (x % 3);
      req_valid = 4'(1 << (x % 4));
      req_data = '0;
      req_data[(x % 4)*8 +: 8] = 8'(x);
      start_txn($sformatf("exh%0d", x), 4'(1 << (x % 4)), 8'(x));
      req_valid = '0;
      wait_rsp($sformatf("exh%0d", x), core_lat + 2, 2'(x % 4), 1'b0);
      rt = int'(rsp_root);
      chk($sformatf("exh_root x=%0d r=%0d", x, rt), 32'((rt * rt <= x) && ((rt + 1) * (rt + 1) > x)), 32'(1));
      finish_rsp($sformatf("exh%0d", x));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
